// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scanning channel multiplexer:
// FSM state encoding, mode encoding and select-width helper.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIXED = 2'd1,
    SCAN  = 2'd2
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  // Select width never collapses to zero, even for a degenerate channel count.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Control, data and status bundle of scan_mux; master drives the controls,
// slave (the multiplexer) drives the registered results.
interface scan_mux_if
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int DWELL_W  = 8
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [DWELL_W-1:0]        dwell;
  logic [CHANNELS*WIDTH-1:0] a;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;
  logic                      sel_err;

  modport master (
    output en, mode, sel, dwell, a,
    input  y, ch, valid, wrap, sel_err
  );

  modport slave (
    input  en, mode, sel, dwell, a,
    output y, ch, valid, wrap, sel_err
  );

endinterface

// File: rtl/scan_mux_mux_n.sv
// Purely combinational CHANNELS:1 selector; an index beyond the last
// channel yields zero so the output is always defined.
module mux_n
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = sel_width(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [SEL_W-1:0]          idx,
  output logic [WIDTH-1:0]          y
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0] chan_s [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign chan_s[k] = a[k*WIDTH +: WIDTH];
  end

  // Bounded lookup into the unpacked channel array.
  always_comb begin
    y = '0;
    if ({1'b0, idx} < CH_LIM) begin
      y = chan_s[idx];
    end else begin
      y = '0;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with fixed-select and round-robin scan
// modes; each scanned channel is held for dwell+1 cycles.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int DWELL_W  = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  scan_mux_if.slave bus
);

  localparam int              SEL_W   = sel_width(CHANNELS);
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_e             state_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [WIDTH-1:0]   y_r;
  logic [SEL_W-1:0]   ch_r;
  logic               valid_r;
  logic               wrap_r;
  logic               sel_err_r;

  logic               sel_ok_s;
  logic               adv_s;
  logic [SEL_W-1:0]   next_ch_s;
  logic [SEL_W-1:0]   mux_idx_s;
  logic [WIDTH-1:0]   mux_y_s;

  // Picks the channel that will drive y after the coming edge.
  // A larger counter than a freshly lowered dwell also advances.
  always_comb begin
    sel_ok_s  = ({1'b0, bus.sel} < CH_LIM);
    adv_s     = (cnt_r >= bus.dwell);
    next_ch_s = (ch_r == LAST_CH) ? '0 : ch_r + SEL_W'(1);
    if (bus.mode == MODE_FIXED) begin
      mux_idx_s = bus.sel;
    end else if (state_r != SCAN) begin
      mux_idx_s = sel_ok_s ? bus.sel : '0;
    end else if (adv_s) begin
      mux_idx_s = next_ch_s;
    end else begin
      mux_idx_s = ch_r;
    end
  end

  mux_n #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_mux (
    .a   (bus.a),
    .idx (mux_idx_s),
    .y   (mux_y_s)
  );

  // Mode FSM with registered data and status outputs; en=0 wins over mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      y_r       <= '0;
      ch_r      <= '0;
      valid_r   <= 1'b0;
      wrap_r    <= 1'b0;
      sel_err_r <= 1'b0;
    end else if (!bus.en) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      valid_r   <= 1'b0;
      wrap_r    <= 1'b0;
      sel_err_r <= 1'b0;
    end else if (bus.mode == MODE_FIXED) begin
      state_r   <= FIXED;
      cnt_r     <= '0;
      wrap_r    <= 1'b0;
      valid_r   <= sel_ok_s;
      sel_err_r <= !sel_ok_s;
      if (sel_ok_s) begin
        y_r  <= mux_y_s;
        ch_r <= bus.sel;
      end else begin
        y_r  <= y_r;
        ch_r <= ch_r;
      end
    end else begin
      case (state_r)
        SCAN: begin
          cnt_r     <= adv_s ? '0 : cnt_r + DWELL_W'(1);
          wrap_r    <= adv_s && (ch_r == LAST_CH);
          sel_err_r <= 1'b0;
        end
        default: begin
          cnt_r     <= '0;
          wrap_r    <= 1'b0;
          sel_err_r <= !sel_ok_s;
        end
      endcase
      state_r <= SCAN;
      y_r     <= mux_y_s;
      ch_r    <= mux_idx_s;
      valid_r <= 1'b1;
    end
  end

  assign bus.y       = y_r;
  assign bus.ch      = ch_r;
  assign bus.valid   = valid_r;
  assign bus.wrap    = wrap_r;
  assign bus.sel_err = sel_err_r;

endmodule
